// File: rtl/decode_stage.sv
// Registered RV32I decode stage: output register plus one skid entry, flushable.
// Optional macro DECODE_RV32M_EN enables decoding of the M extension as MULDIV.
module decode_stage #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [3:0]      out_op,
    output logic [2:0]      out_funct3,
    output logic            out_alt,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic            out_rd_we,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal
);

    typedef enum logic [3:0] {
        OP_LUI     = 4'd0,
        OP_AUIPC   = 4'd1,
        OP_JAL     = 4'd2,
        OP_JALR    = 4'd3,
        OP_BRANCH  = 4'd4,
        OP_LOAD    = 4'd5,
        OP_STORE   = 4'd6,
        OP_OPIMM   = 4'd7,
        OP_OP      = 4'd8,
        OP_FENCE   = 4'd9,
        OP_SYSTEM  = 4'd10,
        OP_MULDIV  = 4'd11,
        OP_ILLEGAL = 4'd15
    } op_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [3:0]      op;
        logic [2:0]      funct3;
        logic            alt;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            rd_we;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } entry_t;

    entry_t or_q, sk_q, decoded;
    logic   or_valid, sk_valid, accept;

    op_t         d_op;
    logic        d_legal, d_alt, d_use_rd, d_use_rs1, d_use_rs2;
    logic [31:0] d_imm32;

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];
    assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u  = {in_instr[31:12], 12'b0};
    assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    // Opcode classification; anything not matched below (including instr[1:0]!=11) stays illegal.
    always_comb begin
        d_op      = OP_ILLEGAL;
        d_legal   = 1'b0;
        d_alt     = 1'b0;
        d_use_rd  = 1'b0;
        d_use_rs1 = 1'b0;
        d_use_rs2 = 1'b0;
        d_imm32   = '0;
        case (opcode)
            7'b0110111: begin d_op = OP_LUI;   d_legal = 1'b1; d_use_rd = 1'b1; d_imm32 = imm_u; end
            7'b0010111: begin d_op = OP_AUIPC; d_legal = 1'b1; d_use_rd = 1'b1; d_imm32 = imm_u; end
            7'b1101111: begin d_op = OP_JAL;   d_legal = 1'b1; d_use_rd = 1'b1; d_imm32 = imm_j; end
            7'b1100111: begin
                d_op = OP_JALR; d_legal = (funct3 == 3'd0);
                d_use_rd = 1'b1; d_use_rs1 = 1'b1; d_imm32 = imm_i;
            end
            7'b1100011: begin
                d_op = OP_BRANCH; d_legal = (funct3 != 3'd2) && (funct3 != 3'd3);
                d_use_rs1 = 1'b1; d_use_rs2 = 1'b1; d_imm32 = imm_b;
            end
            7'b0000011: begin
                d_op = OP_LOAD; d_legal = !(funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7);
                d_use_rd = 1'b1; d_use_rs1 = 1'b1; d_imm32 = imm_i;
            end
            7'b0100011: begin
                d_op = OP_STORE; d_legal = (funct3 <= 3'd2);
                d_use_rs1 = 1'b1; d_use_rs2 = 1'b1; d_imm32 = imm_s;
            end
            7'b0010011: begin
                d_op = OP_OPIMM; d_legal = 1'b1;
                d_use_rd = 1'b1; d_use_rs1 = 1'b1; d_imm32 = imm_i;
                if (funct3 == 3'd1) begin
                    d_legal = (funct7 == 7'h00);
                    d_alt   = in_instr[30];
                end else if (funct3 == 3'd5) begin
                    d_legal = (funct7 == 7'h00) || (funct7 == 7'h20);
                    d_alt   = in_instr[30];
                end
            end
            7'b0110011: begin
                d_op = OP_OP; d_alt = in_instr[30];
                d_use_rd = 1'b1; d_use_rs1 = 1'b1; d_use_rs2 = 1'b1;
                if (funct7 == 7'h00)
                    d_legal = 1'b1;
                else if (funct7 == 7'h20)
                    d_legal = (funct3 == 3'd0) || (funct3 == 3'd5);
`ifdef DECODE_RV32M_EN
                else if (funct7 == 7'h01) begin
                    d_op    = OP_MULDIV;
                    d_legal = 1'b1;
                end
`else
                else
                    d_legal = 1'b0;
`endif
            end
            7'b0001111: begin d_op = OP_FENCE; d_legal = 1'b1; end
            7'b1110011: begin
                d_op = OP_SYSTEM; d_imm32 = imm_i;
                d_legal = (in_instr == 32'h0000_0073) || (in_instr == 32'h0010_0073);
            end
            default: d_legal = 1'b0;
        endcase
    end

    // Illegal words still flow down the pipe, but carry no operands.
    always_comb begin
        decoded         = '0;
        decoded.pc      = in_pc;
        decoded.funct3  = funct3;
        decoded.illegal = !d_legal;
        decoded.op      = d_legal ? d_op : OP_ILLEGAL;
        if (d_legal) begin
            decoded.alt   = d_alt;
            decoded.rd    = d_use_rd  ? in_instr[11:7]  : 5'd0;
            decoded.rs1   = d_use_rs1 ? in_instr[19:15] : 5'd0;
            decoded.rs2   = d_use_rs2 ? in_instr[24:20] : 5'd0;
            decoded.rd_we = d_use_rd && (in_instr[11:7] != 5'd0);
            decoded.imm   = XLEN'($signed(d_imm32));
        end
    end

    // in_ready depends only on local state, never on out_ready.
    assign in_ready = !sk_valid && !rst && !flush;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            or_valid <= 1'b0;
            sk_valid <= 1'b0;
            or_q     <= '0;
            sk_q     <= '0;
        end else if (flush) begin
            or_valid <= 1'b0;
            sk_valid <= 1'b0;
        end else if (!or_valid || out_ready) begin
            if (sk_valid) begin
                or_q     <= sk_q;
                or_valid <= 1'b1;
                sk_valid <= 1'b0;
            end else begin
                or_valid <= accept;
                if (accept)
                    or_q <= decoded;
            end
        end else if (accept) begin
            sk_q     <= decoded;
            sk_valid <= 1'b1;
        end
    end

    assign out_valid   = or_valid;
    assign out_pc      = or_q.pc;
    assign out_op      = or_q.op;
    assign out_funct3  = or_q.funct3;
    assign out_alt     = or_q.alt;
    assign out_rd      = or_q.rd;
    assign out_rs1     = or_q.rs1;
    assign out_rs2     = or_q.rs2;
    assign out_rd_we   = or_q.rd_we;
    assign out_imm     = or_q.imm;
    assign out_illegal = or_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, decode vectors, back-pressure, flush.
// Honours DECODE_RV32M_EN for the MUL expectation.
module tb_decode_stage;
    localparam int XLEN = 32;
    localparam int PC_W = 32;

    logic            clk = 1'b0;
    logic            rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc, out_pc;
    logic [3:0]      out_op;
    logic [2:0]      out_funct3;
    logic            out_alt, out_rd_we, out_illegal;
    logic [4:0]      out_rd, out_rs1, out_rs2;
    logic [XLEN-1:0] out_imm;

    int vectors = 0;
    int miscompares = 0;

    decode_stage #(.XLEN(XLEN), .PC_W(PC_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_op(out_op),
        .out_funct3(out_funct3), .out_alt(out_alt), .out_rd(out_rd), .out_rs1(out_rs1),
        .out_rs2(out_rs2), .out_rd_we(out_rd_we), .out_imm(out_imm), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] instr, input logic [PC_W-1:0] pc);
        in_valid  = 1'b1;
        in_instr  = instr;
        in_pc     = pc;
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
    endtask

    task automatic checkDecode(input string tag, input logic [PC_W-1:0] pc, input logic [3:0] op,
                               input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [63:0] imm, input logic rd_we, input logic illegal);
        checkOutput({tag, "_valid"},   out_valid, 1);
        checkOutput({tag, "_pc"},      out_pc, pc);
        checkOutput({tag, "_op"},      out_op, op);
        checkOutput({tag, "_rd"},      out_rd, rd);
        checkOutput({tag, "_rs1"},     out_rs1, rs1);
        checkOutput({tag, "_rs2"},     out_rs2, rs2);
        checkOutput({tag, "_imm"},     out_imm, imm);
        checkOutput({tag, "_rd_we"},   out_rd_we, rd_we);
        checkOutput({tag, "_illegal"}, out_illegal, illegal);
    endtask

    function automatic logic [31:0] streamInstr(input int i);
        return 32'h0000_0013 | (32'(i + 1) << 7);
    endfunction

    initial begin
        int   idx;
        int   got;
        int   cycles;
        logic acc;

        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h0050_0093; in_pc = '0;
        #1;
        checkOutput("rst_in_ready", in_ready, 0);
        step();
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_op", out_op, 0);
        checkOutput("rst_out_illegal", out_illegal, 0);
        checkOutput("rst_out_imm", out_imm, 0);
        checkOutput("rst_out_rd_we", out_rd_we, 0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", in_ready, 1);

        // Single-instruction decode vectors, out_ready held high
        applyStimulus(32'h0050_0093, 32'h1000);
        checkDecode("addi", 32'h1000, 4'd7, 5'd1, 5'd0, 5'd0, 64'h5, 1'b1, 1'b0);
        applyStimulus(32'hFE00_0EE3, 32'h1004);
        checkDecode("beq", 32'h1004, 4'd4, 5'd0, 5'd0, 5'd0, 64'hFFFF_FFFC, 1'b0, 1'b0);
        applyStimulus(32'h0000_A0B3, 32'h1008);
        checkDecode("slt", 32'h1008, 4'd8, 5'd1, 5'd1, 5'd0, 64'h0, 1'b1, 1'b0);
        applyStimulus(32'h8000_02B7, 32'h100C);
        checkDecode("lui", 32'h100C, 4'd0, 5'd5, 5'd0, 5'd0, 64'h8000_0000, 1'b1, 1'b0);
        applyStimulus(32'h0000_0000, 32'h1010);
        checkDecode("zero_word", 32'h1010, 4'd15, 5'd0, 5'd0, 5'd0, 64'h0, 1'b0, 1'b1);
        applyStimulus(32'h4000_A0B3, 32'h1014);
        checkDecode("op_f7_20_f3_2", 32'h1014, 4'd15, 5'd0, 5'd0, 5'd0, 64'h0, 1'b0, 1'b1);
        applyStimulus(32'h0000_B083, 32'h1018);
        checkDecode("load_f3_3", 32'h1018, 4'd15, 5'd0, 5'd0, 5'd0, 64'h0, 1'b0, 1'b1);
        applyStimulus(32'h0220_8033, 32'h101C);
`ifdef DECODE_RV32M_EN
        checkDecode("mul", 32'h101C, 4'd11, 5'd0, 5'd1, 5'd2, 64'h0, 1'b0, 1'b0);
`else
        checkDecode("mul", 32'h101C, 4'd15, 5'd0, 5'd0, 5'd0, 64'h0, 1'b0, 1'b1);
`endif
        step();
        checkOutput("drained_out_valid", out_valid, 0);

        // Back-pressure: stream four with out_ready low
        idx = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = (idx < 4);
            in_instr = streamInstr(idx);
            in_pc    = 32'h2000 + 32'(idx * 4);
            #1;
            acc = in_valid && in_ready;
            step();
            if (acc) idx++;
        end
        checkOutput("bp_accepts", idx, 2);
        checkOutput("bp_in_ready", in_ready, 0);
        for (int c = 0; c < 5; c++) begin
            step();
            checkOutput("bp_hold_valid", out_valid, 1);
            checkOutput("bp_hold_pc", out_pc, 32'h2000);
            checkOutput("bp_hold_rd", out_rd, 1);
        end

        out_ready = 1'b1;
        got = 0;
        cycles = 0;
        while (got < 4 && cycles < 20) begin
            in_valid = (idx < 4);
            in_instr = streamInstr(idx);
            in_pc    = 32'h2000 + 32'(idx * 4);
            #1;
            acc = in_valid && in_ready;
            if (out_valid) begin
                checkOutput("bp_order_pc", out_pc, 32'h2000 + 32'(got * 4));
                checkOutput("bp_order_rd", out_rd, 5'(got + 1));
                got++;
            end
            step();
            cycles++;
            if (acc) idx++;
        end
        in_valid = 1'b0;
        checkOutput("bp_delivered", got, 4);
        checkOutput("bp_cycles", cycles, 4);

        // Fill OR and SK, then flush while a third word is presented
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b1;
            in_instr = streamInstr(c);
            in_pc    = 32'h3000 + 32'(c * 4);
            step();
        end
        checkOutput("flush_pre_in_ready", in_ready, 0);
        in_instr = 32'h0070_0393;
        in_pc    = 32'h3008;
        flush    = 1'b1;
        #1;
        checkOutput("flush_in_ready", in_ready, 0);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("flush_out_valid", out_valid, 0);
        checkOutput("flush_post_in_ready", in_ready, 1);
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            checkOutput("flush_no_output", out_valid, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
